// File: rtl/player_hit_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : player_hit_scheduler
//  Description : Scans every enemy bullet slot once per frame through a single
//                shared hitbox comparator. Retires the first bullet that hits,
//                owns the player health counter and the post-hit
//                invulnerability window, and raises boom on death.
//                Optional macro PLAYER_SHIELD_EN adds a one-hit shield.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_hit_scheduler #(
  parameter int N_SLOTS     = 8,
  parameter int IDX_W       = 3,
  parameter int INIT_HEALTH = 3,
  parameter int INV_FRAMES  = 60,
  parameter int HB_XL       = 10,
  parameter int HB_XR       = 50,
  parameter int HB_YT       = 50,
  parameter int HB_YB       = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             restart,
  input  logic             my_en,
  input  logic [9:0]       p_x,
  input  logic [9:0]       p_y,
  output logic [IDX_W-1:0] slot_idx,
  input  logic [9:0]       slot_x,
  input  logic [9:0]       slot_y,
  input  logic             slot_en,
  output logic             kill_valid,
  output logic [IDX_W-1:0] kill_idx,
  output logic [3:0]       health,
  output logic             hit_pulse,
  output logic             invuln,
  output logic             busy,
  output logic             boom
`ifdef PLAYER_SHIELD_EN
  ,
  input  logic             shield_grant,
  output logic             shield
`endif
);

  localparam int c_inv_w = $clog2(INV_FRAMES + 1);

  localparam logic [10:0]        c_hb_xl    = 11'(HB_XL);
  localparam logic [10:0]        c_hb_xr    = 11'(HB_XR);
  localparam logic [10:0]        c_hb_yt    = 11'(HB_YT);
  localparam logic [10:0]        c_hb_yb    = 11'(HB_YB);
  localparam logic [3:0]         c_init_hp  = 4'(INIT_HEALTH);
  localparam logic [c_inv_w-1:0] c_inv_load = c_inv_w'(INV_FRAMES);
  localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(N_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_INV  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  state_t             r_state,    w_state_nxt;
  logic [IDX_W-1:0]   r_slot_idx, w_slot_idx_nxt;
  logic [3:0]         r_health,   w_health_nxt;
  logic [c_inv_w-1:0] r_inv_cnt,  w_inv_cnt_nxt;
  logic               r_kill,     w_kill_nxt;
  logic [IDX_W-1:0]   r_kill_idx, w_kill_idx_nxt;
  logic               r_shield,   w_shield_nxt;
  logic               w_shield_used;
  logic               w_grant;

  // Hitbox test on the addressed slot; 11-bit operands so additions never wrap.
  logic w_hit_xl, w_hit_xr, w_hit_yt, w_hit_yb, w_hit;
  assign w_hit_xl = ({1'b0, p_x} + c_hb_xl) >= {1'b0, slot_x};
  assign w_hit_xr = {1'b0, p_x} < ({1'b0, slot_x} + c_hb_xr);
  assign w_hit_yt = ({1'b0, p_y} + c_hb_yt) >= {1'b0, slot_y};
  assign w_hit_yb = {1'b0, p_y} < ({1'b0, slot_y} + c_hb_yb);
  assign w_hit    = slot_en & w_hit_xl & w_hit_xr & w_hit_yt & w_hit_yb;

`ifdef PLAYER_SHIELD_EN
  assign w_grant = shield_grant;
  assign shield  = r_shield;
`else
  assign w_grant = 1'b0;
`endif

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_slot_idx <= '0;
      r_health   <= c_init_hp;
      r_inv_cnt  <= '0;
      r_kill     <= 1'b0;
      r_kill_idx <= '0;
      r_shield   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot_idx <= w_slot_idx_nxt;
      r_health   <= w_health_nxt;
      r_inv_cnt  <= w_inv_cnt_nxt;
      r_kill     <= w_kill_nxt;
      r_kill_idx <= w_kill_idx_nxt;
      r_shield   <= w_shield_nxt;
    end
  end

  // Next-state and datapath updates; restart overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_slot_idx_nxt = r_slot_idx;
    w_health_nxt   = r_health;
    w_inv_cnt_nxt  = r_inv_cnt;
    w_kill_nxt     = 1'b0;
    w_kill_idx_nxt = r_kill_idx;
    w_shield_nxt   = r_shield;
    w_shield_used  = 1'b0;

    if (restart) begin
      w_state_nxt    = ST_IDLE;
      w_slot_idx_nxt = '0;
      w_health_nxt   = c_init_hp;
      w_inv_cnt_nxt  = '0;
      w_shield_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (frame_tick && my_en && (r_health != 4'd0)) begin
            w_state_nxt    = ST_SCAN;
            w_slot_idx_nxt = '0;
          end
        end
        ST_SCAN: begin
          if (w_hit) begin
            // First hit ends the frame's scan; only one hit per frame.
            w_kill_nxt     = 1'b1;
            w_kill_idx_nxt = r_slot_idx;
            w_slot_idx_nxt = '0;
            if (r_shield) begin
              w_shield_nxt  = 1'b0;
              w_shield_used = 1'b1;
              w_state_nxt   = ST_IDLE;
            end else if (r_health <= 4'd1) begin
              w_health_nxt = 4'd0;
              w_state_nxt  = ST_DEAD;
            end else begin
              w_health_nxt  = r_health - 4'd1;
              w_inv_cnt_nxt = c_inv_load;
              w_state_nxt   = ST_INV;
            end
          end else if ((r_slot_idx == c_last_idx) || !my_en) begin
            w_state_nxt    = ST_IDLE;
            w_slot_idx_nxt = '0;
          end else begin
            w_slot_idx_nxt = r_slot_idx + 1'b1;
          end
        end
        ST_INV: begin
          if (r_inv_cnt == '0) begin
            w_state_nxt = ST_IDLE;
          end else if (frame_tick) begin
            w_inv_cnt_nxt = r_inv_cnt - 1'b1;
            if (r_inv_cnt == c_inv_w'(1)) begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: begin
          w_health_nxt = 4'd0;
          w_shield_nxt = 1'b0;
        end
      endcase

      // A grant is ignored in the cycle a shield absorbs a hit and on death.
      if (w_grant && !w_shield_used && (w_state_nxt != ST_DEAD)) begin
        w_shield_nxt = 1'b1;
      end
      if (w_state_nxt == ST_DEAD) begin
        w_shield_nxt = 1'b0;
      end
    end
  end

  assign slot_idx   = r_slot_idx;
  assign kill_valid = r_kill;
  assign hit_pulse  = r_kill;
  assign kill_idx   = r_kill_idx;
  assign health     = r_health;
  assign busy       = (r_state == ST_SCAN);
  assign invuln     = (r_state == ST_INV);
  assign boom       = (r_state == ST_DEAD);

endmodule
`default_nettype wire
